// File: rtl/wb_test_reporter.sv
// Wishbone classic slave that compares EXPECTED/MEASURED pairs and produces a pass/fail verdict.
// Optional watchdog: define WB_TEST_REPORTER_TIMEOUT_EN to fail a RUNNING test that goes quiet.
`timescale 1ns/1ps
module wb_test_reporter #(
  parameter int unsigned NUM_TESTS      = 16,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        test_passed_o,
  output logic        test_failed_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PASSED  = 2'd2,
    ST_FAILED  = 2'd3
  } state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_EXPECTED = 3'd1;
  localparam logic [2:0] A_MEASURED = 3'd2;
  localparam logic [2:0] A_TCOUNT   = 3'd3;
  localparam logic [2:0] A_FCOUNT   = 3'd4;
  localparam logic [2:0] A_FF_IDX   = 3'd5;
  localparam logic [2:0] A_FF_EXP   = 3'd6;
  localparam logic [2:0] A_FF_MEAS  = 3'd7;

  state_t             r_state;
  state_t             r_prev_state;
  logic               r_ack;
  logic [31:0]        r_dat_o;
  logic               r_irq;
  logic [31:0]        r_expected;
  logic [31:0]        r_measured;
  logic [CNT_W-1:0]   r_test_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic [CNT_W-1:0]   r_ff_idx;
  logic [31:0]        r_ff_exp;
  logic [31:0]        r_ff_meas;
  logic               r_fail_sticky;
`ifdef WB_TEST_REPORTER_TIMEOUT_EN
  logic [31:0]        r_wdog;
`endif

  logic               w_req;
  logic               w_wr;
  logic [2:0]         w_sel;
  logic [31:0]        w_rdata;
  logic               w_done_ok;
  logic               w_unused;

  always_comb begin
    w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    w_wr      = w_req & wb_we_i;
    w_sel     = wb_adr_i[4:2];
    // Compare at 32 bits so a saturated narrow counter cannot alias NUM_TESTS.
    w_done_ok = (r_fail_cnt == '0) && (32'(r_test_cnt) == 32'(NUM_TESTS));
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_CTRL:     w_rdata = {29'b0, r_fail_sticky, r_state};
      A_EXPECTED: w_rdata = r_expected;
      A_MEASURED: w_rdata = r_measured;
      A_TCOUNT:   w_rdata = 32'(r_test_cnt);
      A_FCOUNT:   w_rdata = 32'(r_fail_cnt);
      A_FF_IDX:   w_rdata = 32'(r_ff_idx);
      A_FF_EXP:   w_rdata = r_ff_exp;
      A_FF_MEAS:  w_rdata = r_ff_meas;
      default:    w_rdata = '0;
    endcase
  end

`ifdef WB_TEST_REPORTER_TIMEOUT_EN
  assign w_unused = ^{wb_sel_i, wb_adr_i[1:0]};
`else
  assign w_unused = ^{wb_sel_i, wb_adr_i[1:0], 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state       <= ST_IDLE;
      r_prev_state  <= ST_IDLE;
      r_ack         <= 1'b0;
      r_dat_o       <= '0;
      r_irq         <= 1'b0;
      r_expected    <= '0;
      r_measured    <= '0;
      r_test_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_ff_idx      <= '0;
      r_ff_exp      <= '0;
      r_ff_meas     <= '0;
      r_fail_sticky <= 1'b0;
`ifdef WB_TEST_REPORTER_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_ack        <= w_req;
      r_dat_o      <= w_req ? w_rdata : '0;
      r_prev_state <= r_state;
      r_irq        <= ((r_state == ST_PASSED) || (r_state == ST_FAILED)) &&
                      (r_prev_state != r_state);

`ifdef WB_TEST_REPORTER_TIMEOUT_EN
      // Watchdog is evaluated first; an acked write on the same edge overrides it.
      if (w_wr) begin
        r_wdog <= '0;
      end else if (r_state == ST_RUNNING) begin
        if (r_wdog >= 32'(TIMEOUT_CYCLES - 1)) r_state <= ST_FAILED;
        else                                   r_wdog  <= r_wdog + 32'd1;
      end
`endif

      if (w_wr) begin
        case (w_sel)
          A_CTRL: begin
            if (wb_dat_i[0]) begin
              r_state       <= ST_RUNNING;
              r_test_cnt    <= '0;
              r_fail_cnt    <= '0;
              r_ff_idx      <= '0;
              r_ff_exp      <= '0;
              r_ff_meas     <= '0;
              r_fail_sticky <= 1'b0;
            end else if (wb_dat_i[1] && (r_state == ST_RUNNING)) begin
              r_state <= w_done_ok ? ST_PASSED : ST_FAILED;
            end
          end
          A_EXPECTED: r_expected <= wb_dat_i;
          A_MEASURED: begin
            r_measured <= wb_dat_i;
            if (r_state == ST_RUNNING) begin
              if (r_test_cnt != '1) r_test_cnt <= r_test_cnt + 1'b1;
              if (r_expected != wb_dat_i) begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
                if (!r_fail_sticky) begin
                  r_ff_idx  <= r_test_cnt;
                  r_ff_exp  <= r_expected;
                  r_ff_meas <= wb_dat_i;
                end
                r_fail_sticky <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o      = r_ack;
  assign wb_dat_o      = r_dat_o;
  assign irq_o         = r_irq;
  assign test_passed_o = (r_state == ST_PASSED);
  assign test_failed_o = (r_state == ST_FAILED);

endmodule

// File: tb/tb_wb_test_reporter.sv
// Directed self-checking bench for wb_test_reporter with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_test_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  adr = '0;
  logic [31:0] dat_w = '0;
  logic [31:0] dat_r;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic        passed;
  logic        failed;
  logic        irq;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  wb_test_reporter #(
    .NUM_TESTS(16),
    .CNT_W(16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_w),
    .wb_dat_o(dat_r),
    .wb_sel_i(sel),
    .wb_we_i(we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_ack_o(ack),
    .test_passed_o(passed),
    .test_failed_o(failed),
    .irq_o(irq)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [2:0] ra, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    logic got_ack;
    got_ack = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = {ra, 2'b00}; dat_w = wdata; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        break;
      end
    end
    rdata = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    expect_eq("ack", {31'b0, got_ack}, 32'd1);
  endtask

  task automatic wr(input logic [2:0] ra, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus(1'b1, ra, d, unused_rd);
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] ra, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, ra, '0, v);
    expect_eq(tag, v, exp);
  endtask

  task automatic count_irq(output int unsigned n);
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (irq) n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_ack",    {31'b0, ack},    32'd0);
    expect_eq("rst_dat",    dat_r,           32'd0);
    expect_eq("rst_passed", {31'b0, passed}, 32'd0);
    expect_eq("rst_failed", {31'b0, failed}, 32'd0);
    expect_eq("rst_irq",    {31'b0, irq},    32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] meas_val(input int unsigned i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 9) return 32'h00000099;
    return 32'(i);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;

    // Reset state and register contents
    do_reset();
    chk_reg("ctrl_rst",  3'd0, 32'h0);
    chk_reg("tcnt_rst",  3'd3, 32'h0);
    chk_reg("fcnt_rst",  3'd4, 32'h0);
    chk_reg("ffidx_rst", 3'd5, 32'h0);
    chk_reg("ffexp_rst", 3'd6, 32'h0);
    chk_reg("ffmeas_rst",3'd7, 32'h0);

    // 16 passing tests -> PASSED
    wr(3'd0, 32'h1);
    chk_reg("ctrl_running", 3'd0, 32'h1);
    for (int unsigned i = 0; i < 16; i++) begin
      wr(3'd1, 32'(i));
      wr(3'd2, 32'(i));
    end
    wr(3'd0, 32'h2);
    count_irq(n);
    expect_eq("pass_irq_pulses", 32'(n), 32'd1);
    expect_eq("pass_passed_o", {31'b0, passed}, 32'd1);
    expect_eq("pass_failed_o", {31'b0, failed}, 32'd0);
    chk_reg("pass_ctrl", 3'd0, 32'h2);
    chk_reg("pass_tcnt", 3'd3, 32'd16);
    chk_reg("pass_fcnt", 3'd4, 32'd0);

    // Two mismatches (tests 5 and 9) -> FAILED, first failure captured
    wr(3'd0, 32'h1);
    chk_reg("restart_tcnt", 3'd3, 32'd0);
    for (int unsigned i = 0; i < 16; i++) begin
      wr(3'd1, 32'(i));
      wr(3'd2, meas_val(i));
    end
    chk_reg("fail_run_ctrl", 3'd0, 32'h5);
    wr(3'd0, 32'h2);
    count_irq(n);
    expect_eq("fail_irq_pulses", 32'(n), 32'd1);
    expect_eq("fail_failed_o", {31'b0, failed}, 32'd1);
    expect_eq("fail_passed_o", {31'b0, passed}, 32'd0);
    chk_reg("fail_ctrl",   3'd0, 32'h7);
    chk_reg("fail_tcnt",   3'd3, 32'd16);
    chk_reg("fail_fcnt",   3'd4, 32'd2);
    chk_reg("fail_ffidx",  3'd5, 32'd5);
    chk_reg("fail_ffexp",  3'd6, 32'd5);
    chk_reg("fail_ffmeas", 3'd7, 32'hDEADBEEF);
    chk_reg("fail_exp",    3'd1, 32'd15);
    chk_reg("fail_meas",   3'd2, 32'd15);

    // 15 passing tests is one short -> FAILED without sticky; START re-arms
    wr(3'd0, 32'h1);
    for (int unsigned i = 0; i < 15; i++) begin
      wr(3'd1, 32'(i + 100));
      wr(3'd2, 32'(i + 100));
    end
    wr(3'd0, 32'h2);
    chk_reg("short_ctrl", 3'd0, 32'h3);
    chk_reg("short_tcnt", 3'd3, 32'd15);
    wr(3'd2, 32'h1234);
    chk_reg("term_tcnt_frozen", 3'd3, 32'd15);
    wr(3'd0, 32'h1);
    chk_reg("rerun_ctrl", 3'd0, 32'h1);
    chk_reg("rerun_tcnt", 3'd3, 32'd0);

    // Writes outside RUNNING, and START+DONE together
    do_reset();
    wr(3'd2, 32'hCAFEF00D);
    chk_reg("idle_tcnt", 3'd3, 32'd0);
    chk_reg("idle_meas", 3'd2, 32'hCAFEF00D);
    wr(3'd0, 32'h2);
    chk_reg("idle_done_ctrl", 3'd0, 32'h0);
    wr(3'd0, 32'h3);
    chk_reg("start_wins_ctrl", 3'd0, 32'h1);

    // Reset asserted while a START write is outstanding
    do_reset();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'd0; dat_w = 32'h1; rst = 1'b1;
    @(posedge clk); #1;
    expect_eq("midrst_ack", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    chk_reg("midrst_ctrl", 3'd0, 32'h0);

`ifdef WB_TEST_REPORTER_TIMEOUT_EN
    // Watchdog: a write before the limit keeps RUNNING; silence afterwards fails it
    wr(3'd0, 32'h1);
    repeat (90) @(posedge clk);
    wr(3'd1, 32'h5);
    chk_reg("wdog_alive_ctrl", 3'd0, 32'h1);
    n = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (irq) n++;
    end
    expect_eq("wdog_irq_pulses", 32'(n), 32'd1);
    expect_eq("wdog_failed_o", {31'b0, failed}, 32'd1);
    chk_reg("wdog_ctrl", 3'd0, 32'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
